buttons_irq_controller: RTL and testbench

//  Parametrised N-channel push-button controller on the shared memory-mapped bus; next generation of the 4-button block.
//  Per channel: input synchroniser, counter debouncer, selectable press/release edge detect, sticky pending bit, interrupt enable.

---
 rtl/buttons_irq_controller_pkg.sv | 27 ++
 rtl/buttons_irq_controller_if.sv | 11 +
 rtl/buttons_irq_controller_debouncer.sv | 47 ++++
 rtl/buttons_irq_controller.sv | 81 ++++++++
 tb/tb_buttons_irq_controller.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/buttons_irq_controller_pkg.sv
// Shared definitions for the push-button interrupt controller: register
// indices, CTRL bit positions and bus data helpers.
package buttons_irq_controller_pkg;

  typedef enum logic [1:0] {
    REG_CTRL    = 2'd0,
    REG_IE      = 2'd1,
    REG_PENDING = 2'd2,
    REG_STATE   = 2'd3
  } reg_idx_e;

  localparam int CTRL_IRQ_EN   = 0;
  localparam int CTRL_EDGE_SEL = 1;
  localparam logic [31:0] CTRL_MASK = 32'h0000_0003;

  function automatic logic [31:0] byte_en(input logic [3:0] mask);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{mask[i]}};
    return m;
  endfunction

  // Read data is right-aligned to the addressed byte lane.
  function automatic logic [31:0] rd_shift(input logic [31:0] word, input logic [1:0] off);
    return word >> {off, 3'b000};
  endfunction

endpackage

// File: rtl/buttons_irq_controller_if.sv
// Bus request signals shared by the bus master and the button controller;
// data_bus and fc_bus are tristate and stay plain ports on the controller.
interface buttons_irq_controller_if;
  logic [31:0] addr_bus;
  logic        rd_bus;
  logic        wr_bus;
  logic [3:0]  data_mask_bus;

  modport master (output addr_bus, rd_bus, wr_bus, data_mask_bus);
  modport slave  (input  addr_bus, rd_bus, wr_bus, data_mask_bus);
endinterface

// File: rtl/buttons_irq_controller_debouncer.sv
// One button channel: synchroniser chain, counter debouncer and
// single-cycle rise/fall pulses of the debounced level.
module button_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;
  logic                   level_d;
  logic                   sync_lvl;

  assign sync_lvl = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q  <= '0;
      cnt     <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], btn};
      level_d <= level;
      // Any return to the current level restarts the stability window.
      if (sync_lvl == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync_lvl;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign rise = level & ~level_d;
  assign fall = ~level & level_d;

endmodule

// File: rtl/buttons_irq_controller.sv
// N-channel debounced push-button controller with sticky pending flags,
// per-channel enables and a registered level interrupt, on the shared bus.
module buttons_irq_controller import buttons_irq_controller_pkg::*; #(
  parameter logic [31:0] START_ADDR      = 32'h0,
  parameter int          CHANNELS        = 4,
  parameter int          DEBOUNCE_CYCLES = 1000,
  parameter int          SYNC_STAGES     = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CHANNELS-1:0]     btn,
  output logic                    interrupt,
  buttons_irq_controller_if.slave bus,
  inout  wire  [31:0]             data_bus,
  output wire                     fc_bus
);
  localparam logic [31:0] CH_MASK = 32'((64'd1 << CHANNELS) - 64'd1);

  logic [CHANNELS-1:0] state, rise, fall;
  logic [31:0] ctrl_r, ie_r, pend_r;
  logic [31:0] bm, incoming, ev, clr, rword, rdata;
  logic        hit, read_req, write_req, commit, data_written;
  reg_idx_e    idx;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    button_debouncer #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk  (clk),
      .rst  (rst),
      .btn  (btn[i]),
      .level(state[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end

  assign hit       = bus.addr_bus[31:4] == START_ADDR[31:4];
  assign idx       = reg_idx_e'(bus.addr_bus[3:2]);
  assign read_req  = hit & bus.rd_bus;
  assign write_req = hit & bus.wr_bus;
  assign commit    = write_req & ~data_written;

  assign bm       = byte_en(bus.data_mask_bus);
  assign incoming = data_bus & bm;
  assign ev       = 32'(ctrl_r[CTRL_EDGE_SEL] ? fall : rise);
  assign clr      = (commit && idx == REG_PENDING) ? (incoming & CH_MASK) : 32'h0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ctrl_r       <= '0;
      ie_r         <= '0;
      pend_r       <= '0;
      data_written <= 1'b0;
      interrupt    <= 1'b0;
    end else begin
      if (commit && idx == REG_CTRL) ctrl_r <= ((ctrl_r & ~bm) | incoming) & CTRL_MASK;
      if (commit && idx == REG_IE)   ie_r   <= ((ie_r & ~bm) | incoming) & CH_MASK;
      // A new event outranks a simultaneous clear of the same bit.
      pend_r       <= (pend_r & ~clr) | ev;
      data_written <= bus.wr_bus & (data_written | write_req);
      interrupt    <= ctrl_r[CTRL_IRQ_EN] & |(pend_r & ie_r);
    end
  end

  always_comb begin
    rword = 32'h0;
    unique case (idx)
      REG_CTRL:    rword = ctrl_r;
      REG_IE:      rword = ie_r;
      REG_PENDING: rword = pend_r;
      REG_STATE:   rword = 32'(state);
    endcase
  end

  assign rdata    = rd_shift(rword, bus.addr_bus[1:0]);
  assign data_bus = read_req ? rdata : 32'hz;
  assign fc_bus   = hit ? (read_req | data_written) : 1'bz;

endmodule

// File: tb/tb_buttons_irq_controller.sv
// Self-checking bench: directed scenarios plus randomized buttons/bus traffic
// against a window-based reference model of debounce, pending and interrupt.
module tb_buttons_irq_controller;
  localparam logic [31:0] BASE = 32'h1000;
  localparam int CH = 8, DEB = 4, SYNC = 2;
  localparam int HIST = SYNC + DEB - 1;
  localparam logic [31:0] A_CTRL = BASE, A_IE = BASE + 4, A_PEND = BASE + 8, A_STATE = BASE + 12;

  logic clk, rst;
  logic [CH-1:0] btn;
  logic interrupt;
  wire  [31:0] data_bus;
  wire  fc_bus;
  logic tb_drv;
  logic [31:0] tb_wdata;

  buttons_irq_controller_if bus_if();
  assign data_bus = tb_drv ? tb_wdata : 32'hz;

  buttons_irq_controller #(
    .START_ADDR(BASE), .CHANNELS(CH), .DEBOUNCE_CYCLES(DEB), .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk), .rst(rst), .btn(btn), .interrupt(interrupt),
    .bus(bus_if.slave), .data_bus(data_bus), .fc_bus(fc_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;

  // ---------------- reference model ----------------
  logic          m_wr_go;
  logic [31:0]   m_wr_addr, m_wr_data;
  logic [3:0]    m_wr_mask;
  logic [CH-1:0] sh [HIST];
  logic [CH-1:0] db_m, flip_prev, ie_m, pend_m;
  logic [1:0]    ctrl_m;
  logic          irq_m;
  logic [31:0]   m_bm;
  logic [CH-1:0] m_clr, m_ev, m_all1, m_all0, m_flip;

  function automatic logic [31:0] expand(input logic [3:0] mk);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = {8{mk[i]}};
    return r;
  endfunction

  // Debounced level flips once the last DEB synchronised samples all
  // disagree with it; synchronised sample = raw sample SYNC cycles ago.
  always_comb begin
    m_bm   = expand(m_wr_mask);
    m_clr  = '0;
    if (m_wr_go && m_wr_addr[3:2] == 2'd2) m_clr = m_wr_data[CH-1:0] & m_bm[CH-1:0];
    m_ev   = (ctrl_m[1] ? ~db_m : db_m) & flip_prev;
    m_all1 = '1;
    m_all0 = '1;
    for (int j = SYNC - 1; j < HIST; j++) begin
      m_all1 = m_all1 & sh[j];
      m_all0 = m_all0 & ~sh[j];
    end
    m_flip = (m_all1 & ~db_m) | (m_all0 & db_m);
  end

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < HIST; i++) sh[i] <= '0;
      db_m <= '0; flip_prev <= '0; ctrl_m <= '0; ie_m <= '0; pend_m <= '0; irq_m <= 1'b0;
    end else begin
      if (m_wr_go && m_wr_addr[3:2] == 2'd0) ctrl_m <= (ctrl_m & ~m_bm[1:0]) | (m_wr_data[1:0] & m_bm[1:0]);
      if (m_wr_go && m_wr_addr[3:2] == 2'd1) ie_m <= (ie_m & ~m_bm[CH-1:0]) | (m_wr_data[CH-1:0] & m_bm[CH-1:0]);
      pend_m    <= (pend_m & ~m_clr) | m_ev;
      irq_m     <= ctrl_m[0] & |(pend_m & ie_m);
      db_m      <= db_m ^ m_flip;
      flip_prev <= m_flip;
      sh[0]     <= btn;
      for (int i = 1; i < HIST; i++) sh[i] <= sh[i-1];
    end
  end

  function automatic logic [31:0] model_reg(input logic [1:0] idx);
    case (idx)
      2'd0:    return {30'h0, ctrl_m};
      2'd1:    return 32'(ie_m);
      2'd2:    return 32'(pend_m);
      default: return 32'(db_m);
    endcase
  endfunction

  // ---------------- bus tasks (enter and leave just after a negedge) ----------------
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
    bus_if.addr_bus = addr; bus_if.data_mask_bus = mask; bus_if.wr_bus = 1'b1;
    tb_wdata = data; tb_drv = 1'b1;
    m_wr_addr = addr; m_wr_data = data; m_wr_mask = mask; m_wr_go = 1'b1;
    @(negedge clk);
    m_wr_go = 1'b0; bus_if.wr_bus = 1'b0; tb_drv = 1'b0; bus_if.addr_bus = 32'h0;
    @(negedge clk);
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data, output logic fc);
    bus_if.addr_bus = addr; bus_if.rd_bus = 1'b1;
    #1;
    data = data_bus; fc = fc_bus;
    @(negedge clk);
    bus_if.rd_bus = 1'b0; bus_if.addr_bus = 32'h0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] d; logic fc;
    rst = 1'b0; btn = '1;
    repeat (3) @(negedge clk);
    rst = 1'b1; btn = '0;
    n_checks++; if (interrupt !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b exp 0", interrupt); end
    for (int i = 0; i < 4; i++) begin
      bus_read(BASE + 32'(4 * i), d, fc);
      n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_reg%0d got %h exp 0", i, d); end
      n_checks++; if (fc !== 1'b1) begin n_fail++; $display("FAIL reset_rd_fc%0d got %b exp 1", i, fc); end
    end
    tb_drv = 1'b1; tb_wdata = 32'h5A5A_A5A5; #1;
    n_checks++; if (data_bus !== 32'h5A5A_A5A5) begin n_fail++; $display("FAIL idle_data_bus got %h exp 5a5aa5a5", data_bus); end
    n_checks++; if (fc_bus === 1'b1) begin n_fail++; $display("FAIL idle_fc got %b exp z", fc_bus); end
    tb_drv = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_glitch();
    logic [31:0] d; logic fc;
    btn[2] = 1'b1; repeat (3) @(negedge clk); btn[2] = 1'b0;
    repeat (10) @(negedge clk);
    bus_read(A_STATE, d, fc);
    n_checks++; if (d !== 32'h0 || d !== model_reg(2'd3)) begin n_fail++; $display("FAIL glitch_state got %h exp 0", d); end
    bus_read(A_PEND, d, fc);
    n_checks++; if (d !== 32'h0 || d !== model_reg(2'd2)) begin n_fail++; $display("FAIL glitch_pend got %h exp 0", d); end
    btn[2] = 1'b1; repeat (10) @(negedge clk);
    bus_read(A_STATE, d, fc);
    n_checks++; if (d !== 32'h04 || d !== model_reg(2'd3)) begin n_fail++; $display("FAIL press_state got %h exp 04", d); end
    bus_read(A_PEND, d, fc);
    n_checks++; if (d !== 32'h04 || d !== model_reg(2'd2)) begin n_fail++; $display("FAIL press_pend got %h exp 04", d); end
  endtask

  task automatic test_irq();
    btn[2] = 1'b0; repeat (10) @(negedge clk);
    bus_write(A_PEND, 32'h04, 4'hF);
    bus_write(A_IE, 32'h04, 4'hF);
    bus_write(A_CTRL, 32'h01, 4'hF);
    n_checks++; if (interrupt !== 1'b0) begin n_fail++; $display("FAIL irq_idle got %b exp 0", interrupt); end
    btn[2] = 1'b1; repeat (10) @(negedge clk);
    n_checks++; if (interrupt !== 1'b1 || irq_m !== 1'b1) begin n_fail++; $display("FAIL irq_set got %b exp 1", interrupt); end
    bus_if.addr_bus = A_PEND; bus_if.data_mask_bus = 4'hF; bus_if.wr_bus = 1'b1;
    tb_wdata = 32'h04; tb_drv = 1'b1;
    m_wr_addr = A_PEND; m_wr_data = 32'h04; m_wr_mask = 4'hF; m_wr_go = 1'b1;
    @(negedge clk);
    m_wr_go = 1'b0;
    n_checks++; if (interrupt !== 1'b1) begin n_fail++; $display("FAIL irq_clr_lat got %b exp 1", interrupt); end
    bus_if.wr_bus = 1'b0; tb_drv = 1'b0; bus_if.addr_bus = 32'h0;
    @(negedge clk);
    n_checks++; if (interrupt !== 1'b0 || irq_m !== 1'b0) begin n_fail++; $display("FAIL irq_clr got %b exp 0", interrupt); end
  endtask

  task automatic test_release();
    logic [31:0] d; logic fc;
    bus_write(A_CTRL, 32'h03, 4'hF);
    btn[5] = 1'b1; repeat (10) @(negedge clk);
    bus_read(A_PEND, d, fc);
    n_checks++; if (d[5] !== 1'b0 || d !== model_reg(2'd2)) begin n_fail++; $display("FAIL rel_press_pend got %h exp bit5=0", d); end
    btn[5] = 1'b0; repeat (10) @(negedge clk);
    bus_read(A_PEND, d, fc);
    n_checks++; if (d !== 32'h20 || d !== model_reg(2'd2)) begin n_fail++; $display("FAIL rel_pend got %h exp 20", d); end
    n_checks++; if (interrupt !== 1'b0) begin n_fail++; $display("FAIL rel_irq got %b exp 0", interrupt); end
  endtask

  task automatic test_byte_mask();
    logic [31:0] d; logic fc;
    bus_if.addr_bus = A_IE; bus_if.data_mask_bus = 4'b0001; bus_if.wr_bus = 1'b1;
    tb_wdata = 32'hAABB_CCDD; tb_drv = 1'b1;
    m_wr_addr = A_IE; m_wr_data = 32'hAABB_CCDD; m_wr_mask = 4'b0001; m_wr_go = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      m_wr_go = 1'b0;
      tb_wdata = 32'h1122_3344;  // a second commit would load 44
      n_checks++; if (fc_bus !== 1'b1) begin n_fail++; $display("FAIL hold_fc%0d got %b exp 1", i, fc_bus); end
    end
    bus_if.wr_bus = 1'b0;
    @(negedge clk);
    n_checks++; if (fc_bus !== 1'b0) begin n_fail++; $display("FAIL fc_drop got %b exp 0", fc_bus); end
    tb_drv = 1'b0; bus_if.addr_bus = 32'h0;
    bus_read(A_IE, d, fc);
    n_checks++; if (d !== 32'hDD || d !== model_reg(2'd1)) begin n_fail++; $display("FAIL mask_ie got %h exp dd", d); end
    bus_write(A_IE, 32'h0000_0011, 4'b1110);
    bus_read(A_IE, d, fc);
    n_checks++; if (d !== 32'hDD) begin n_fail++; $display("FAIL mask_keep got %h exp dd", d); end
    bus_read(A_IE + 1, d, fc);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL rd_shift got %h exp 0", d); end
  endtask

  task automatic test_race();
    logic [31:0] d; logic fc;
    bus_write(A_CTRL, 32'h01, 4'hF);
    bus_write(A_PEND, 32'hFF, 4'hF);
    btn[1] = 1'b1;
    repeat (6) @(negedge clk);
    bus_write(A_PEND, 32'h02, 4'hF);  // commits on the edge that records the press
    repeat (2) @(negedge clk);
    bus_read(A_PEND, d, fc);
    n_checks++; if (d !== 32'h02 || d !== model_reg(2'd2)) begin n_fail++; $display("FAIL race_pend got %h exp 02", d); end
    bus_write(A_PEND, 32'h02, 4'hF);
    bus_read(A_PEND, d, fc);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL w1c_pend got %h exp 0", d); end
  endtask

  task automatic test_random();
    logic [31:0] d, exp_d; logic fc; logic [1:0] idx;
    bus_write(A_IE, 32'hFF, 4'hF);
    for (int it = 0; it < 80; it++) begin
      btn = btn ^ CH'($urandom & $urandom & $urandom);
      repeat ($urandom_range(1, 8)) begin
        @(negedge clk);
        n_checks++; if (interrupt !== irq_m) begin n_fail++; $display("FAIL rnd_irq it%0d got %b exp %b", it, interrupt, irq_m); end
      end
      idx = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: bus_write(BASE + {28'h0, idx, 2'b00}, $urandom, 4'($urandom));
        1, 2: begin
          exp_d = model_reg(idx);
          bus_read(BASE + {28'h0, idx, 2'b00}, d, fc);
          n_checks++; if (d !== exp_d) begin n_fail++; $display("FAIL rnd_reg%0d it%0d got %h exp %h", idx, it, d, exp_d); end
        end
        default: ;
      endcase
    end
  endtask

  initial begin
    rst = 1'b0; btn = '0; tb_drv = 1'b0; tb_wdata = '0;
    bus_if.addr_bus = 32'h0; bus_if.rd_bus = 1'b0; bus_if.wr_bus = 1'b0; bus_if.data_mask_bus = 4'h0;
    m_wr_go = 1'b0; m_wr_addr = '0; m_wr_data = '0; m_wr_mask = '0;
    test_reset();
    test_glitch();
    test_irq();
    test_release();
    test_byte_mask();
    test_race();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
